generation_step_sequencer: RTL

- Consumes the one-cycle generation tick from the variable clock divider and turns it into a request/acknowledge step handshake with the board update engine.
- Adds run/pause and single-step button control, one-deep tick queueing, overrun and timeout flags, and a generation counter for display.
- Sits between the clock divider and the life-update engine, in the same cin domain.

---
 rtl/generation_step_sequencer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/generation_step_sequencer.sv
// Step sequencer between the generation clock divider and the life-update engine.
// Turns divider ticks or a debounced single-step press into a req/done handshake.
module generation_step_sequencer #(
    parameter int unsigned GEN_W      = 16,
    parameter int unsigned DEB_CYCLES = 500000,
    parameter int unsigned TIMEOUT    = 1048576
) (
    input  logic             cin,
    input  logic             rst,
    input  logic             tick_in,
    input  logic             run_bttn,
    input  logic             step_bttn,
    input  logic             step_done,
    output logic             step_req,
    output logic             running,
    output logic             busy,
    output logic [GEN_W-1:0] gen_count,
    output logic             overrun,
    output logic             timeout_err
);

    localparam int unsigned DW = $clog2(DEB_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [DW-1:0] DEB_FULL = DW'(DEB_CYCLES);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT - 1);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t          state;
    logic [1:0]      bttn_raw;
    logic [1:0]      sync1;
    logic [1:0]      sync2;
    logic [1:0]      press;
    logic [DW-1:0]   deb_cnt [2];
    logic            tick_q;
    logic            tick_rise;
    logic            run_press;
    logic            step_press;
    logic            trigger;
    logic            pending;
    logic [TW-1:0]   tmo_cnt;

    // Bit 0 is the run button, bit 1 the single-step button.
    assign bttn_raw = {step_bttn, run_bttn};

    always_ff @(posedge cin) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            sync1 <= bttn_raw;
            sync2 <= sync1;
            // Counter saturates at DEB_CYCLES so a held button fires only once.
            for (int unsigned i = 0; i < 2; i++) begin
                if (!sync2[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] != DEB_FULL) begin
                    deb_cnt[i] <= deb_cnt[i] + DW'(1);
                end
            end
        end
    end

    always_comb begin
        press = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            press[i] = sync2[i] && (deb_cnt[i] == DEB_LAST);
        end
    end

    assign run_press  = press[0];
    assign step_press = press[1];
    assign tick_rise  = tick_in & ~tick_q;
    assign trigger    = (running & tick_rise) | (~running & step_press);

    always_ff @(posedge cin) begin
        if (rst) begin
            state       <= IDLE;
            step_req    <= 1'b0;
            running     <= 1'b0;
            busy        <= 1'b0;
            gen_count   <= '0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
            pending     <= 1'b0;
            tmo_cnt     <= '0;
            tick_q      <= 1'b0;
        end else begin
            tick_q <= tick_in;
            if (run_press) begin
                running <= ~running;
            end

            case (state)
                IDLE: begin
                    if (trigger || pending) begin
                        step_req <= 1'b1;
                        busy     <= 1'b1;
                        pending  <= 1'b0;
                        tmo_cnt  <= TMO_LOAD;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (trigger) begin
                        if (!pending) begin
                            pending <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end
                    if (step_done) begin
                        step_req  <= 1'b0;
                        busy      <= 1'b0;
                        gen_count <= gen_count + GEN_W'(1);
                        state     <= IDLE;
                    end else if (tmo_cnt == '0) begin
                        step_req    <= 1'b0;
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                        pending     <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt - TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase

            // A pause discards any queued step; this overrides the WAIT-state set above.
            if (run_press && running) begin
                pending <= 1'b0;
            end
        end
    end

endmodule
